// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO between the UART receiver and transmitter.
// Single clock domain. Overflow of a write while full is flagged stickily.
module uart_byte_fifo #(
    parameter int DW         = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_wr_valid,
    input  logic [DW-1:0]         i_wr_data,
    output logic                  o_rd_valid,
    output logic [DW-1:0]         o_rd_data,
    input  logic                  i_rd_ready,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overflow,
    input  logic                  i_clr_overflow
);

    localparam int                DEPTH   = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DW-1:0]         mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  overflow_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic [DEPTH_LOG2:0]   count_next_s;

    // Handshake decode; a pop frees a slot so a full FIFO can still accept a write.
    always_comb begin
        full_s  = (count_r == DEPTH_C);
        empty_s = (count_r == {(DEPTH_LOG2 + 1){1'b0}});
        pop_s   = ~empty_s & i_rd_ready;
        push_s  = i_wr_valid & (~full_s | pop_s);
        drop_s  = i_wr_valid & full_s & ~pop_s;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
            2'b01:   count_next_s = count_r - {{DEPTH_LOG2{1'b0}}, 1'b1};
            default: count_next_s = count_r;
        endcase
    end

    // Storage array; reset zeroes every entry so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= i_wr_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            count_r  <= {(DEPTH_LOG2 + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};
            end
            count_r <= count_next_s;
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (i_clr_overflow) begin
            overflow_r <= 1'b0;
        end
    end

    assign o_rd_data  = mem_r[rd_ptr_r];
    assign o_rd_valid = ~empty_s;
    assign o_empty    = empty_s;
    assign o_full     = full_s;
    assign o_count    = count_r;
    assign o_overflow = overflow_r;

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Directed plus randomized bench for uart_byte_fifo, checked against a queue model.
module tb_uart_byte_fifo;

    logic       clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_wr_valid = 1'b0;
    logic [7:0] i_wr_data = 8'h00;
    logic       o_rd_valid;
    logic [7:0] o_rd_data;
    logic       i_rd_ready = 1'b0;
    logic       o_full;
    logic       o_empty;
    logic [4:0] o_count;
    logic       o_overflow;
    logic       i_clr_overflow = 1'b0;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_q [$];
    bit         model_ovf = 1'b0;
    int         pushed;

    uart_byte_fifo #(.DW(8), .DEPTH_LOG2(4)) dut (
        .clk            (clk),
        .i_reset        (i_reset),
        .i_wr_valid     (i_wr_valid),
        .i_wr_data      (i_wr_data),
        .o_rd_valid     (o_rd_valid),
        .o_rd_data      (o_rd_data),
        .i_rd_ready     (i_rd_ready),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_count        (o_count),
        .o_overflow     (o_overflow),
        .i_clr_overflow (i_clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with the model state.
    task automatic check_all(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ".count"},    32'(o_count),    32'(sz));
        check({tag, ".empty"},    32'(o_empty),    32'(sz == 0));
        check({tag, ".full"},     32'(o_full),     32'(sz == 16));
        check({tag, ".rd_valid"}, 32'(o_rd_valid), 32'(sz != 0));
        check({tag, ".overflow"}, 32'(o_overflow), 32'(model_ovf));
        if (sz != 0) begin
            check({tag, ".rd_data"}, 32'(o_rd_data), 32'(model_q[0]));
        end
    endtask

    // Apply inputs for one clock, advance the model by the FIFO rules, then check.
    task automatic cycle(input string tag, input bit wv, input logic [7:0] wd,
                         input bit rd, input bit clr, input bit rst_n);
        int  sz;
        bit  pop;
        bit  push;
        bit  drop;
        i_wr_valid     = wv;
        i_wr_data      = wd;
        i_rd_ready     = rd;
        i_clr_overflow = clr;
        i_reset        = rst_n;
        @(posedge clk);
        sz = model_q.size();
        if (!rst_n) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            pop  = (sz > 0) && rd;
            push = wv && ((sz < 16) || pop);
            drop = wv && (sz == 16) && !pop;
            if (pop) void'(model_q.pop_front());
            if (push) begin
                model_q.push_back(wd);
                pushed++;
            end
            if (drop) model_ovf = 1'b1;
            else if (clr) model_ovf = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        // 1: reset held two cycles with a write pending
        cycle("rst0", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        cycle("rst1", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        check("rst.rd_data_zero", 32'(o_rd_data), 32'h0);
        check("rst.count_zero",   32'(o_count),   32'h0);

        // 2: single byte with one-cycle latency, then pop
        cycle("single_wr", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        check("single.data", 32'(o_rd_data), 32'hA5);
        cycle("single_rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("single.empty", 32'(o_empty), 32'h1);

        // 3: fill, overflow drop, drain in order
        for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        check("fill.full", 32'(o_full), 32'h1);
        cycle("ovf_wr", 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        check("ovf.flag",  32'(o_overflow), 32'h1);
        check("ovf.count", 32'(o_count),    32'd16);
        for (int i = 0; i < 16; i++) begin
            check("drain.order", 32'(o_rd_data), 32'(i));
            cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        end
        cycle("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // 4: full + write + pop in the same cycle
        for (int i = 0; i < 16; i++) cycle("fill2", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b1);
        cycle("full_wr_rd", 1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        check("full_wr_rd.count", 32'(o_count),    32'd16);
        check("full_wr_rd.ovf",   32'(o_overflow), 32'h0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("full_wr_rd.last", 32'(o_rd_data), 32'h77);
            cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        end

        // 5: random traffic through several pointer wraps
        pushed = 0;
        for (int n = 0; n < 600 && pushed < 40; n++) begin
            bit wv;
            bit rd;
            wv = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            if (model_q.size() == 16) rd = 1'b1;
            cycle("rand", wv, 8'($urandom), rd, 1'b0, 1'b1);
        end
        check("rand.pushed", 32'(pushed >= 40), 32'h1);
        for (int n = 0; n < 20 && model_q.size() > 0; n++) cycle("rand_drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("rand.drained", 32'(o_empty), 32'h1);

        // 6: reset mid-operation, then clear racing a drop
        for (int i = 0; i < 5; i++) cycle("fill5", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
        cycle("mid_rst", 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        check("mid_rst.count", 32'(o_count), 32'h0);
        check("mid_rst.empty", 32'(o_empty), 32'h1);
        for (int i = 0; i < 16; i++) cycle("fill3", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b1);
        cycle("set_ovf", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        cycle("clr_vs_drop", 1'b1, 8'hBB, 1'b0, 1'b1, 1'b1);
        check("clr_vs_drop.ovf", 32'(o_overflow), 32'h1);
        cycle("clr_only", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check("clr_only.ovf", 32'(o_overflow), 32'h0);
        cycle("hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
